input_debounce: RTL and testbench
=================================

// Module: input_debounce
// PURPOSE
//  Per-bit debounce filter placed directly after the 3-stage synchronizer on Pocket controller/button inputs.
//  Accepts already-synchronized levels and rejects bounce/glitches shorter than a stability window.
//  Emits clean levels plus registered one-cycle press/release pulses for core input logic.
//  Operates in a single clock domain; inputs must already be synchronous to clk.
// PARAMETERS
//  WIDTH       16     number of independent input bits
//  PRESCALE    1      clk cycles per sample tick (1 = sample every cycle)
//  STABLE_CYC  4      consecutive differing tick-samples required to accept a new level (>=1)
//  CNT_W       16     width of stability/repeat counters; must hold max(STABLE_CYC, REPEAT_DLY, REPEAT_RATE)
//  RESET_VAL   '0     value of o during and after reset, per bit
//  REPEAT_DLY  8      ticks held before first repeat pulse (repeat build only)
//  REPEAT_RATE 4      ticks between subsequent repeat pulses (repeat build only)
// PORTS
//  clk      in   1      core clock
//  reset_n  in   1      asynchronous active-low reset
//  i        in   WIDTH  synchronized raw levels (synchronizer output)
//  o        out  WIDTH  debounced levels
//  rise     out  WIDTH  one-cycle pulse when o bit goes 0->1
//  fall     out  WIDTH  one-cycle pulse when o bit goes 1->0
//  rep      out  WIDTH  one-cycle auto-repeat pulse while o bit held 1 (0 when feature compiled out)
// BEHAVIOUR
//  Reset (async assert, sync release): o=RESET_VAL, rise=fall=rep=0, all counters 0, prescaler 0, every channel in STABLE.
//  Tick: shared prescaler counts 0..PRESCALE-1; tick=1 on the cycle the count equals PRESCALE-1 (every cycle if PRESCALE=1).
//  Per-channel FSM, two states; transitions evaluated only on tick cycles:
//   STABLE: cnt=0. On tick with i!=o, go to SETTLING with cnt=1.
//    If STABLE_CYC=1, instead update o directly and pulse the edge output.
//   SETTLING: on tick with i==o, return to STABLE with cnt=0 (glitch rejected, no pulse).
//    On tick with i!=o and cnt<STABLE_CYC-1, increment cnt.
//    On tick with i!=o and cnt==STABLE_CYC-1, o<=i, pulse rise or fall, go to STABLE.
//  Latency (PRESCALE=1): o changes on the STABLE_CYC-th clock edge after i first differs; the pulse is valid the same cycle o changes.
//  rise/fall are registered. They are high exactly one clk cycle and never simultaneously high on one bit.
//  Channels are fully independent; simultaneous changes on several bits produce simultaneous pulses.
//  Reset mid-settling abandons the count. After release, a bit with i!=RESET_VAL debounces normally and emits its pulse.
//  Non-tick cycles hold all state; rise/fall return to 0 after one cycle regardless of tick.
// CONFIGURATION
//  Macro INPUT_DEBOUNCE_REPEAT_EN:
//   Defined: per-bit repeat counter runs on ticks while o=1.
//    rep pulses one cycle when the held count reaches REPEAT_DLY, then every REPEAT_RATE ticks after that.
//    The counter clears on fall or reset; no rep pulse is issued on the rise cycle.
//   Undefined: rep tied to '0 and no repeat counters are generated.
// STRUCTURE
//  Package input_debounce_pkg: typedef enum logic {DB_STABLE, DB_SETTLING} db_state_t.
//  Sub-module debounce_ch: one channel (FSM, stability counter, optional repeat counter); instantiated WIDTH times in a generate loop.
//  Top level holds the shared prescaler and tick generation.
//  Elaboration assertions: STABLE_CYC>=1, PRESCALE>=1, REPEAT_RATE>=1, and the CNT_W range check.
// TESTING (WIDTH=4, PRESCALE=1, STABLE_CYC=4, RESET_VAL=0 unless noted)
//  1 Clean press: i[0] 0->1 and held -> o[0]=1 and rise[0]=1 for one cycle, 4 edges later; fall stays 0.
//  2 Glitch: i[1]=1 for 2 cycles, then 0 -> o[1] stays 0; no rise/fall pulses.
//  3 Bounce: i[2] toggles 1,0,1,1,0 then held 1 -> exactly one rise[2], 4 edges after the final 0->1.
//  4 Reset mid-settle: i[0]=1, assert reset_n=0 after 2 cycles, release -> o=0 during reset; rise[0] 4 edges after release.
//  5 Parallel and prescale: PRESCALE=3, i=4'b1010 at once -> rise=4'b1010 in a single cycle, 12 edges later; then i=0 -> fall=4'b1010.
//  6 Repeat (macro on, DLY=8, RATE=4): hold i[3]=1 -> rep[3] pulses 8 ticks after rise, then every 4 ticks; release -> rep stops; with macro off rep==0 throughout.

Source files
------------

// File: rtl/input_debounce_pkg.sv
// rtl/input_debounce_pkg.sv - shared types and helpers for the input_debounce filter
package input_debounce_pkg;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_SETTLING = 1'b1
  } db_state_t;

  // True when a non-negative value is representable in an unsigned counter of the given width.
  function automatic bit cnt_fits(int val, int width);
    if (width >= 31) return 1'b1;
    return val < (1 << width);
  endfunction

endpackage

// File: rtl/input_debounce_ch.sv
// rtl/input_debounce_ch.sv - single-bit debounce channel (module debounce_ch): settle FSM,
// stability counter and, with INPUT_DEBOUNCE_REPEAT_EN, an auto-repeat counter.
module debounce_ch
  import input_debounce_pkg::*;
#(
  parameter int   STABLE_CYC = 4,
  parameter int   CNT_W      = 16,
  parameter logic RESET_BIT  = 1'b0
`ifdef INPUT_DEBOUNCE_REPEAT_EN
  ,
  parameter int   REPEAT_DLY  = 8,
  parameter int   REPEAT_RATE = 4
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic i,
  output logic o,
  output logic rise,
  output logic fall,
  output logic rep
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

  db_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             accept;
  logic             o_n, rise_n, fall_n;
  logic             differ;

  assign differ = (i != o);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= DB_STABLE;
      cnt   <= '0;
      o     <= RESET_BIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      o     <= o_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  // cnt counts consecutive differing ticks already seen; the STABLE_CYC-th one commits.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    if (tick) begin
      case (state)
        DB_STABLE: begin
          if (differ) begin
            if (STABLE_CYC == 1) begin
              accept = 1'b1;
            end else begin
              state_n = DB_SETTLING;
              cnt_n   = CNT_W'(1);
            end
          end
        end
        DB_SETTLING: begin
          if (!differ) begin
            state_n = DB_STABLE;
            cnt_n   = '0;
          end else if (cnt == CNT_LAST) begin
            accept  = 1'b1;
            state_n = DB_STABLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_n = DB_STABLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    o_n    = accept ? i : o;
    rise_n = accept & i;
    fall_n = accept & ~i;
  end

`ifdef INPUT_DEBOUNCE_REPEAT_EN
  logic [CNT_W-1:0] rcnt, rcnt_inc, rthr;
  logic             rfirst_done;
  logic             rep_q;

  // First period is REPEAT_DLY ticks from the rise, later periods REPEAT_RATE ticks.
  assign rcnt_inc = rcnt + CNT_W'(1);
  assign rthr     = rfirst_done ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DLY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt        <= '0;
      rfirst_done <= 1'b0;
      rep_q       <= 1'b0;
    end else begin
      rep_q <= 1'b0;
      if (!o || fall_n) begin
        rcnt        <= '0;
        rfirst_done <= 1'b0;
      end else if (tick) begin
        if (rcnt_inc == rthr) begin
          rep_q       <= 1'b1;
          rcnt        <= '0;
          rfirst_done <= 1'b1;
        end else begin
          rcnt <= rcnt_inc;
        end
      end
    end
  end

  assign rep = rep_q;
`else
  assign rep = 1'b0;
`endif

endmodule

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - per-bit debounce with press/release pulses, shared sample prescaler;
// auto-repeat pulses are built only when INPUT_DEBOUNCE_REPEAT_EN is defined.
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               PRESCALE    = 1,
  parameter int               STABLE_CYC  = 4,
  parameter int               CNT_W       = 16,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int               REPEAT_DLY  = 8,
  parameter int               REPEAT_RATE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] rep
);

  if (STABLE_CYC < 1) begin : g_chk_stable
    $error("input_debounce: STABLE_CYC must be >= 1");
  end
  if (PRESCALE < 1) begin : g_chk_prescale
    $error("input_debounce: PRESCALE must be >= 1");
  end
  if (REPEAT_RATE < 1 || REPEAT_DLY < 1) begin : g_chk_repeat
    $error("input_debounce: REPEAT_DLY and REPEAT_RATE must be >= 1");
  end
  if (!cnt_fits(STABLE_CYC, CNT_W) || !cnt_fits(REPEAT_DLY, CNT_W) ||
      !cnt_fits(REPEAT_RATE, CNT_W)) begin : g_chk_cnt_w
    $error("input_debounce: CNT_W too narrow for STABLE_CYC/REPEAT_DLY/REPEAT_RATE");
  end

  logic tick;

  if (PRESCALE == 1) begin : g_no_prescale
    assign tick = 1'b1;
  end else begin : g_prescale
    localparam int PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    logic [PS_W-1:0] ps_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        ps_cnt <= '0;
      end else if (ps_cnt == PS_LAST) begin
        ps_cnt <= '0;
      end else begin
        ps_cnt <= ps_cnt + PS_W'(1);
      end
    end

    assign tick = (ps_cnt == PS_LAST);
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_ch #(
      .STABLE_CYC (STABLE_CYC),
      .CNT_W      (CNT_W),
      .RESET_BIT  (RESET_VAL[g])
`ifdef INPUT_DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_RATE(REPEAT_RATE)
`endif
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .i      (i[g]),
      .o      (o[g]),
      .rise   (rise[g]),
      .fall   (fall[g]),
      .rep    (rep[g])
    );
  end

endmodule

// File: tb/tb_input_debounce.sv
// tb/tb_input_debounce.sv - self-checking bench for input_debounce (PRESCALE=1 and PRESCALE=3 instances)
module tb_input_debounce;

  localparam int SC   = 4;
  localparam int DLY  = 8;
  localparam int RATE = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] i_a = '0, i_b = '0;
  logic [3:0] o_a, rise_a, fall_a, rep_a;
  logic [3:0] o_b, rise_b, fall_b, rep_b;

  always #5 clk = ~clk;

  input_debounce #(
    .WIDTH(4), .PRESCALE(1), .STABLE_CYC(SC), .CNT_W(16), .RESET_VAL(4'b0000),
    .REPEAT_DLY(DLY), .REPEAT_RATE(RATE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i(i_a), .o(o_a), .rise(rise_a), .fall(fall_a), .rep(rep_a)
  );

  input_debounce #(
    .WIDTH(4), .PRESCALE(3), .STABLE_CYC(SC), .CNT_W(16), .RESET_VAL(4'b0000),
    .REPEAT_DLY(DLY), .REPEAT_RATE(RATE)
  ) dut_p (
    .clk(clk), .reset_n(reset_n), .i(i_b), .o(o_b), .rise(rise_b), .fall(fall_b), .rep(rep_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per bit, a run length of consecutive differing sample ticks and
  // a count of ticks the debounced level has been held high.
  logic [3:0] mo[2], mr[2], mf[2], mp[2];
  int         run[2][4];
  int         held[2][4];
  int         ecnt[2];
  int         ps_of[2] = '{1, 3};

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mo[d] = 4'b0000; mr[d] = '0; mf[d] = '0; mp[d] = '0; ecnt[d] = 0;
      for (int b = 0; b < 4; b++) begin
        run[d][b]  = 0;
        held[d][b] = 0;
      end
    end
  endtask

  task automatic model_edge(int d, logic [3:0] iv);
    bit   tk;
    logic old;
    tk = (ecnt[d] % ps_of[d]) == ps_of[d] - 1;
    ecnt[d]++;
    mr[d] = '0; mf[d] = '0; mp[d] = '0;
    for (int b = 0; b < 4; b++) begin
      old = mo[d][b];
      if (tk) begin
        if (iv[b] != old) begin
          run[d][b]++;
          if (run[d][b] == SC) begin
            mo[d][b]  = iv[b];
            run[d][b] = 0;
            if (iv[b]) mr[d][b] = 1'b1;
            else       mf[d][b] = 1'b1;
          end
        end else begin
          run[d][b] = 0;
        end
      end
`ifdef INPUT_DEBOUNCE_REPEAT_EN
      if (!old || mf[d][b]) begin
        held[d][b] = 0;
      end else if (tk) begin
        held[d][b]++;
        if (held[d][b] == DLY || (held[d][b] > DLY && (held[d][b] - DLY) % RATE == 0))
          mp[d][b] = 1'b1;
      end
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, i_a);
    model_edge(1, i_b);
    #1;
    chk("a_o", o_a, mo[0]);    chk("a_rise", rise_a, mr[0]);
    chk("a_fall", fall_a, mf[0]); chk("a_rep", rep_a, mp[0]);
    chk("b_o", o_b, mo[1]);    chk("b_rise", rise_b, mr[1]);
    chk("b_fall", fall_b, mf[1]); chk("b_rep", rep_b, mp[1]);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    i_a = '0;
    i_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_a", o_a, 0);
    chk("rst_pulses_a", rise_a | fall_a | rep_a, 0);
    chk("rst_o_b", o_b, 0);
    chk("rst_pulses_b", rise_b | fall_b | rep_b, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] i;
    logic [3:0] o;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t tbl[24];

  task automatic run_table();
    // Press on bit0, 2-cycle glitch on bit1, bounce 1,0,1,1,0 then hold on bit2, release bit0.
    tbl[0]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
    tbl[4]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b0011, 4'b0001, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b0011, 4'b0001, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b0101, 4'b0001, 4'b0000, 4'b0000};
    tbl[10] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[11] = '{4'b0101, 4'b0001, 4'b0000, 4'b0000};
    tbl[12] = '{4'b0101, 4'b0001, 4'b0000, 4'b0000};
    tbl[13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[14] = '{4'b0101, 4'b0001, 4'b0000, 4'b0000};
    tbl[15] = '{4'b0101, 4'b0001, 4'b0000, 4'b0000};
    tbl[16] = '{4'b0101, 4'b0001, 4'b0000, 4'b0000};
    tbl[17] = '{4'b0101, 4'b0101, 4'b0100, 4'b0000};
    tbl[18] = '{4'b0101, 4'b0101, 4'b0000, 4'b0000};
    tbl[19] = '{4'b0100, 4'b0101, 4'b0000, 4'b0000};
    tbl[20] = '{4'b0100, 4'b0101, 4'b0000, 4'b0000};
    tbl[21] = '{4'b0100, 4'b0101, 4'b0000, 4'b0000};
    tbl[22] = '{4'b0100, 4'b0100, 4'b0000, 4'b0001};
    tbl[23] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
    apply_reset();
    for (int k = 0; k < 24; k++) begin
      i_a = tbl[k].i;
      step();
      chk($sformatf("tbl%0d_o", k), o_a, tbl[k].o);
      chk($sformatf("tbl%0d_rise", k), rise_a, tbl[k].rise);
      chk($sformatf("tbl%0d_fall", k), fall_a, tbl[k].fall);
    end
  endtask

  task automatic run_mid_reset();
    apply_reset();
    i_a = 4'b0001;
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_o", o_a, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      step();
      chk($sformatf("mid_rst_rise_e%0d", n), rise_a[0], (n == 4) ? 1 : 0);
    end
  endtask

  task automatic run_prescale();
    bit found;
    apply_reset();
    i_b = 4'b1010;
    found = 0;
    for (int e = 1; e <= 40 && !found; e++) begin
      step();
      if (rise_b != 0) begin
        found = 1;
        chk("p_rise_val", rise_b, 4'b1010);
        chk("p_rise_lat", e, 12);
      end
    end
    if (!found) chk("p_rise_timeout", 0, 1);
    i_b = 4'b0000;
    found = 0;
    for (int e = 1; e <= 20 && !found; e++) begin
      step();
      if (fall_b != 0) begin
        found = 1;
        chk("p_fall_val", fall_b, 4'b1010);
      end
    end
    if (!found) chk("p_fall_timeout", 0, 1);
  endtask

  task automatic run_repeat();
    int reps[$];
`ifdef INPUT_DEBOUNCE_REPEAT_EN
    int exp_reps[$] = '{12, 16, 20, 24};
`else
    int exp_reps[$];
`endif
    apply_reset();
    i_a = 4'b1000;
    for (int e = 1; e <= 30; e++) begin
      step();
      if (rep_a[3]) reps.push_back(e);
      if (e == 22) i_a = 4'b0000;
    end
    chk("rep_count", reps.size(), exp_reps.size());
    for (int k = 0; k < exp_reps.size() && k < reps.size(); k++)
      chk($sformatf("rep_edge%0d", k), reps[k], exp_reps[k]);
  endtask

  task automatic run_random();
    int lim;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      lim = ((c / 64) % 2 == 1) ? 1 : 12;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, lim) == 0) i_a[b] = ~i_a[b];
        if ($urandom_range(0, lim) == 0) i_b[b] = ~i_b[b];
      end
      step();
    end
  endtask

  initial begin
    model_reset();
    run_table();
    run_mid_reset();
    run_prescale();
    run_repeat();
    run_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
